// File: rtl/stu_cntl.sv
// Stack-upstream controller: registers the raw stack-bus stream, repairs its packet
// framing and buffers clean words in a FIFO for the return-data processor.
module stu_cntl #(
    parameter int unsigned TAG_W        = 8,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned READY_MARGIN = 3,
    parameter int unsigned ERR_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    input  logic                 stbus__stuc__valid,
    input  logic [1:0]           stbus__stuc__cntl,
    input  logic [TAG_W-1:0]     stbus__stuc__tag,
    input  logic [DATA_W-1:0]    stbus__stuc__data,
    output logic                 stuc__stbus__ready,
    output logic                 stuc__rdp__valid,
    output logic [1:0]           stuc__rdp__cntl,
    output logic [TAG_W-1:0]     stuc__rdp__tag,
    output logic [DATA_W-1:0]    stuc__rdp__data,
    input  logic                 rdp__stuc__ready,
    output logic [ERR_CNT_W-1:0] stuc__sys__frame_err_cnt,
    output logic                 stuc__sys__overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        CNTL_MOM     = 2'b00,
        CNTL_SOM     = 2'b01,
        CNTL_EOM     = 2'b10,
        CNTL_SOM_EOM = 2'b11
    } cntl_e;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } state_e;

    typedef struct packed {
        logic [1:0]        cntl;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } word_t;

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    word_t             hold_q, hold_d;
    logic              in_valid_q;
    word_t             in_q;
    logic              pend_valid_q, pend_valid_d;
    word_t             pend_q, pend_d;

    word_t             mem [FIFO_DEPTH];
    word_t             head;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic              overflow_q, ready_q, ready_d;

    logic              push_held, push_new, trunc, fresh, err_inc;
    logic              first_v, second_v;
    word_t             held_out, first_w;
    logic              fifo_push, fifo_full, fifo_pop, fifo_wr, ovf_set;
    word_t             fifo_w;

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            in_valid_q <= 1'b0;
            in_q       <= '0;
        end else begin
            in_valid_q <= stbus__stuc__valid;
            if (stbus__stuc__valid)
                in_q <= {stbus__stuc__cntl, stbus__stuc__tag, stbus__stuc__data};
        end
    end

    // A truncating SOM/SOM_EOM closes the open packet, then takes the IDLE path.
    always_comb begin
        state_d   = state_q;
        cur_tag_d = cur_tag_q;
        hold_d    = hold_q;
        push_held = 1'b0;
        push_new  = 1'b0;
        trunc     = 1'b0;
        fresh     = 1'b0;
        err_inc   = 1'b0;
        if (in_valid_q) begin
            if (state_q == ST_IN_PKT) begin
                case (cntl_e'(in_q.cntl))
                    CNTL_MOM: begin
                        if (in_q.tag == cur_tag_q) begin
                            push_held = 1'b1;
                            hold_d    = in_q;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                    CNTL_EOM: begin
                        if (in_q.tag == cur_tag_q) begin
                            push_held = 1'b1;
                            push_new  = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                    default: begin
                        push_held = 1'b1;
                        trunc     = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = ST_IDLE;
                        fresh     = 1'b1;
                    end
                endcase
            end else begin
                fresh = 1'b1;
            end
            if (fresh) begin
                case (cntl_e'(in_q.cntl))
                    CNTL_SOM: begin
                        hold_d    = in_q;
                        cur_tag_d = in_q.tag;
                        state_d   = ST_IN_PKT;
                    end
                    CNTL_SOM_EOM: begin
                        push_new = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    default: err_inc = 1'b1;
                endcase
            end
        end
    end

    // The pending word always goes first; any new push then waits in the pending slot.
    always_comb begin
        held_out = hold_q;
        if (trunc)
            held_out.cntl = (hold_q.cntl == CNTL_SOM) ? CNTL_SOM_EOM : CNTL_EOM;
        first_v  = push_held | push_new;
        first_w  = push_held ? held_out : in_q;
        second_v = push_held & push_new;
        pend_d   = pend_q;
        if (pend_valid_q) begin
            fifo_push    = 1'b1;
            fifo_w       = pend_q;
            pend_valid_d = first_v;
            if (first_v)
                pend_d = first_w;
        end else begin
            fifo_push    = first_v;
            fifo_w       = first_w;
            pend_valid_d = second_v;
            if (second_v)
                pend_d = in_q;
        end
    end

    always_comb begin
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_pop  = (count_q != '0) && rdp__stuc__ready;
        fifo_wr   = fifo_push && (!fifo_full || fifo_pop);
        ovf_set   = fifo_push && fifo_full && !fifo_pop;
        count_d   = count_q;
        if (fifo_wr && !fifo_pop)
            count_d = count_q + CNT_W'(1);
        else if (!fifo_wr && fifo_pop)
            count_d = count_q - CNT_W'(1);
        ready_d = (CNT_W'(FIFO_DEPTH) - count_d) >= CNT_W'(READY_MARGIN);
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q      <= ST_IDLE;
            cur_tag_q    <= '0;
            hold_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            cur_tag_q    <= cur_tag_d;
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr_q] <= fifo_w;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (err_inc && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            if (ovf_set)
                overflow_q <= 1'b1;
        end
    end

    assign head                     = mem[rd_ptr_q];
    assign stuc__rdp__valid         = (count_q != '0);
    assign stuc__rdp__cntl          = head.cntl;
    assign stuc__rdp__tag           = head.tag;
    assign stuc__rdp__data          = head.data;
    assign stuc__stbus__ready       = ready_q;
    assign stuc__sys__frame_err_cnt = err_cnt_q;
    assign stuc__sys__overflow      = overflow_q;

endmodule

// File: doc/stu_cntl.md
Name: stu_cntl

Overview:
- Stack-upstream controller: receives the raw upstream stack-bus word stream (valid, cntl, tag, data), checks its packet framing and buffers it in a FIFO.
- Presents a clean, well-framed stream to the return-data processor over a valid/ready interface.
- Sits directly upstream of the return-data processor. That processor holds its ready as a registered signal.
- Repairs truncated packets, drops orphan words, and reports framing errors and overflow to the system.

Parameters:
TAG_W, 8, width of the stack upstream tag
DATA_W, 256, width of the stack upstream data word
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=4)
READY_MARGIN, 3, minimum free FIFO entries needed to assert stack-bus ready
ERR_CNT_W, 16, width of the framing-error counter

Ports:
clk  in  1  sole clock
reset_poweron  in  1  asynchronous, active-low reset
stbus__stuc__valid  in  1  stack-bus word valid
stbus__stuc__cntl  in  2  framing: SOM=2'b01, MOM=2'b00, EOM=2'b10, SOM_EOM=2'b11
stbus__stuc__tag  in  TAG_W  packet tag
stbus__stuc__data  in  DATA_W  payload
stuc__stbus__ready  out  1  flow control to stack bus (registered)
stuc__rdp__valid  out  1  FIFO head valid
stuc__rdp__cntl  out  2  head framing
stuc__rdp__tag  out  TAG_W  head tag
stuc__rdp__data  out  DATA_W  head data
rdp__stuc__ready  in  1  consumer ready
stuc__sys__frame_err_cnt  out  ERR_CNT_W  saturating framing-error count
stuc__sys__overflow  out  1  sticky FIFO overflow flag

Behaviour:
- Reset (reset_poweron low, async):
  - FSM goes to IDLE; hold register and FIFO are cleared.
  - All outputs are 0, including stuc__stbus__ready, stuc__rdp__valid, the error counter and the overflow flag.
  - Reset mid-packet discards all partial data. No word is emitted until a fresh SOM arrives.
- Input is sampled on each clk edge when stbus__stuc__valid=1. Upstream ignores stuc__stbus__ready. The ready signal is advisory with a 2-cycle reaction slack.
- stuc__stbus__ready is registered. It is 1 when free entries >= READY_MARGIN, computed after the current cycle's push and pop.
- FSM states IDLE and IN_PKT, plus a cur_tag register:
  - IDLE + SOM: load hold register, cur_tag <= tag, go to IN_PKT.
  - IDLE + SOM_EOM: push the word directly and stay in IDLE.
  - IDLE + MOM/EOM (orphan): drop the word, increment the error counter, stay in IDLE.
  - IN_PKT + MOM with matching tag: push the held word, load the new word into hold.
  - IN_PKT + EOM with matching tag: push the held word, then push the EOM word. This needs 2 FIFO writes over 2 cycles; the EOM word waits in a one-entry pending slot. Go to IDLE.
  - IN_PKT + MOM/EOM with mismatched tag: drop the word, increment the error counter, state unchanged.
  - IN_PKT + SOM or SOM_EOM (truncation): push the held word with cntl rewritten (SOM->SOM_EOM, MOM->EOM) and increment the error counter.
    - The new word is then handled exactly as in IDLE: SOM loads hold and enters IN_PKT; SOM_EOM is pushed and the FSM returns to IDLE.
- The hold register always holds the newest non-terminal word of the open packet. A packet is therefore always terminated before any later packet's words enter the FIFO.
- Latency:
  - SOM_EOM or EOM sampled at edge N is visible at the FIFO head after edge N+1 if the FIFO was empty. For EOM this is the held word; the EOM itself appears after edge N+2.
  - SOM/MOM words are released only when the next word of the same stream arrives.
- FIFO:
  - Pops when stuc__rdp__valid && rdp__stuc__ready. Head outputs come straight from FIFO storage and are stable while valid=1 and ready=0.
  - Push and pop in the same cycle on a full FIFO are legal: count is unchanged, no overflow.
  - A push when full, with no simultaneous pop, drops the word and sets stuc__sys__overflow. The flag clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH.
- A pending-slot EOM has priority over a new input word's push. If a new word arrives in that cycle, it is processed in IDLE the same cycle, but its push is queued behind the EOM.
- The error counter saturates at all-ones. Simultaneous error sources in one cycle count once.

Test Plan:
1. Reset release; SOM/MOM/MOM/EOM with tag 0x5A, data 1..4; ready=1 -> 4 words out in order, cntl 01,00,00,10, err=0.
2. SOM_EOM with tag 0x11, data 0xAB, FIFO empty -> valid after 1 edge, cntl 11; the FSM stays in IDLE.
3. SOM tag 0x22, MOM tag 0x22, then SOM tag 0x33 -> the MOM is emitted with cntl rewritten to EOM; err=1; the tag 0x33 packet proceeds normally.
4. In IDLE, EOM tag 0x44; then in a packet tagged 0x55, MOM tag 0x66 -> both words dropped, err=2, no output for them.
5. ready=0, 12 consecutive MOM-packet words -> stbus ready falls when free<3; the FIFO fills to 8 and the excess words set overflow=1. Release ready -> exactly 8 words drain intact.
6. Assert reset mid-packet (hold loaded, FIFO with 3 entries) -> valid=0 immediately, err=0, overflow=0. A subsequent MOM is dropped as an orphan and the counter reads 1.
